// File: rtl/move_display_ctrl.sv
// Chess-move display sequencer: scans the four move coordinates through a
// shared digit_writer, latches its segment patterns, then holds them on screen.
module move_display_ctrl #(
  parameter int unsigned HOLD_CYCLES = 50000000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       move_valid,
  output logic       move_ready,
  input  logic [2:0] from_col,
  input  logic [2:0] from_row,
  input  logic [2:0] to_col,
  input  logic [2:0] to_row,
  input  logic       clear,
  output logic [4:0] digit_index,
  input  logic [6:0] seg_in,
  output logic [6:0] hex3,
  output logic [6:0] hex2,
  output logic [6:0] hex1,
  output logic [6:0] hex0,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_SHOW = 2'd2
  } state_t;

  localparam logic [6:0]  SEG_BLANK = 7'h7F;
  localparam logic [25:0] HOLD_LAST = 26'(HOLD_CYCLES - 32'd1);

  state_t      r_state;
  logic [1:0]  r_slot;
  logic [25:0] r_hold_cnt;
  logic [2:0]  r_from_col;
  logic [2:0]  r_from_row;
  logic [2:0]  r_to_col;
  logic [2:0]  r_to_row;
  logic [6:0]  r_hex3;
  logic [6:0]  r_hex2;
  logic [6:0]  r_hex1;
  logic [6:0]  r_hex0;
  logic        r_busy;
  logic [4:0]  w_digit_index;

  // Columns map to the letter glyphs A-H, rows to the digit glyphs 1-8.
  function automatic logic [4:0] col_index(input logic [2:0] col);
    return 5'd9 + {2'b00, col};
  endfunction

  function automatic logic [4:0] row_index(input logic [2:0] row);
    return 5'd1 + {2'b00, row};
  endfunction

  // Index presented to digit_writer for the slot currently being scanned.
  always_comb begin
    w_digit_index = 5'd0;
    if (r_state == ST_SCAN) begin
      case (r_slot)
        2'd0:    w_digit_index = col_index(r_from_col);
        2'd1:    w_digit_index = row_index(r_from_row);
        2'd2:    w_digit_index = col_index(r_to_col);
        2'd3:    w_digit_index = row_index(r_to_row);
        default: w_digit_index = 5'd0;
      endcase
    end else begin
      w_digit_index = 5'd0;
    end
  end

  // Main sequencer: state, counters, latched move and registered displays.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      r_slot     <= 2'd0;
      r_hold_cnt <= 26'd0;
      r_from_col <= 3'd0;
      r_from_row <= 3'd0;
      r_to_col   <= 3'd0;
      r_to_row   <= 3'd0;
      r_hex3     <= SEG_BLANK;
      r_hex2     <= SEG_BLANK;
      r_hex1     <= SEG_BLANK;
      r_hex0     <= SEG_BLANK;
      r_busy     <= 1'b0;
    end else if (clear) begin
      r_state    <= ST_IDLE;
      r_slot     <= 2'd0;
      r_hold_cnt <= 26'd0;
      r_hex3     <= SEG_BLANK;
      r_hex2     <= SEG_BLANK;
      r_hex1     <= SEG_BLANK;
      r_hex0     <= SEG_BLANK;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (move_valid) begin
            r_from_col <= from_col;
            r_from_row <= from_row;
            r_to_col   <= to_col;
            r_to_row   <= to_row;
            r_hex3     <= SEG_BLANK;
            r_hex2     <= SEG_BLANK;
            r_hex1     <= SEG_BLANK;
            r_hex0     <= SEG_BLANK;
            r_slot     <= 2'd0;
            r_hold_cnt <= 26'd0;
            r_busy     <= 1'b1;
            r_state    <= ST_SCAN;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SCAN: begin
          case (r_slot)
            2'd0:    r_hex3 <= seg_in;
            2'd1:    r_hex2 <= seg_in;
            2'd2:    r_hex1 <= seg_in;
            2'd3:    r_hex0 <= seg_in;
            default: r_hex0 <= seg_in;
          endcase
          r_slot <= r_slot + 2'd1;
          if (r_slot == 2'd3) begin
            r_hold_cnt <= 26'd0;
            r_state    <= ST_SHOW;
          end else begin
            r_state <= ST_SCAN;
          end
        end
        ST_SHOW: begin
          // Leave on the terminal count so the counter never wraps.
          if (r_hold_cnt == HOLD_LAST) begin
            r_hold_cnt <= 26'd0;
            r_hex3     <= SEG_BLANK;
            r_hex2     <= SEG_BLANK;
            r_hex1     <= SEG_BLANK;
            r_hex0     <= SEG_BLANK;
            r_busy     <= 1'b0;
            r_state    <= ST_IDLE;
          end else begin
            r_hold_cnt <= r_hold_cnt + 26'd1;
            r_state    <= ST_SHOW;
          end
        end
        default: begin
          r_slot     <= 2'd0;
          r_hold_cnt <= 26'd0;
          r_busy     <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign move_ready  = (r_state == ST_IDLE);
  assign digit_index = w_digit_index;
  assign hex3        = r_hex3;
  assign hex2        = r_hex2;
  assign hex1        = r_hex1;
  assign hex0        = r_hex0;
  assign busy        = r_busy;

endmodule

// File: tb/tb_move_display_ctrl.sv
// Self-checking bench for move_display_ctrl with a behavioural digit_writer,
// directed vector table, corner sequences and a randomized reference model.
module tb_move_display_ctrl;

  localparam int HOLD = 4;

  logic       clock = 1'b0;
  logic       resetn;
  logic       move_valid;
  logic       move_ready;
  logic [2:0] from_col, from_row, to_col, to_row;
  logic       clear;
  logic [4:0] digit_index;
  logic [6:0] seg_in;
  logic [6:0] hex3, hex2, hex1, hex0;
  logic       busy;

  int total = 0;
  int bad   = 0;

  move_display_ctrl #(.HOLD_CYCLES(HOLD)) dut (
    .clock(clock), .resetn(resetn), .move_valid(move_valid), .move_ready(move_ready),
    .from_col(from_col), .from_row(from_row), .to_col(to_col), .to_row(to_row),
    .clear(clear), .digit_index(digit_index), .seg_in(seg_in),
    .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0), .busy(busy)
  );

  always #5 clock = ~clock;

  // digit_writer stand-in: 1..8 digits, 9..16 letters A-H, active-low gfedcba.
  function automatic logic [6:0] seg_of(input logic [4:0] idx);
    case (idx)
      5'd1:  return 7'b1111001;
      5'd2:  return 7'b0100100;
      5'd3:  return 7'b0110000;
      5'd4:  return 7'b0011001;
      5'd5:  return 7'b0010010;
      5'd6:  return 7'b0000010;
      5'd7:  return 7'b1111000;
      5'd8:  return 7'b0000000;
      5'd9:  return 7'b0001000;
      5'd10: return 7'b0000011;
      5'd11: return 7'b1000110;
      5'd12: return 7'b0100001;
      5'd13: return 7'b0000110;
      5'd14: return 7'b0001110;
      5'd15: return 7'b1000010;
      5'd16: return 7'b0001001;
      default: return 7'h7F;
    endcase
  endfunction

  always_comb seg_in = seg_of(digit_index);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    chk({nm, "_ready"}, 32'(move_ready), 32'd1);
    chk({nm, "_idx"}, 32'(digit_index), 32'd0);
    chk({nm, "_hex"}, {4'd0, hex3, hex2, hex1, hex0}, {4'd0, 28'hFFFFFFF});
  endtask

  typedef struct {
    logic [2:0]      fc, fr, tc, tr;
    logic [3:0][4:0] idx;
    logic [3:0][6:0] hex;
  } vec_t;

  vec_t vecs[4];

  // Full move: transfer, scan indices, partial and final hex, dwell, blank.
  task automatic run_move(input vec_t v, input string nm);
    @(negedge clock);
    from_col = v.fc; from_row = v.fr; to_col = v.tc; to_row = v.tr;
    move_valid = 1'b1;
    chk({nm, "_ready_before"}, 32'(move_ready), 32'd1);
    @(posedge clock);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      if (k == 0) move_valid = 1'b0;
      chk($sformatf("%s_idx%0d", nm, k), 32'(digit_index), 32'(v.idx[k]));
      chk($sformatf("%s_busy%0d", nm, k), 32'(busy), 32'd1);
      if (k == 1) begin
        chk({nm, "_hex3_early"}, 32'(hex3), 32'(v.hex[0]));
        chk({nm, "_hex2_blank"}, 32'(hex2), 32'h7F);
      end
    end
    for (int k = 4; k < 4 + HOLD; k++) begin
      @(negedge clock);
      chk($sformatf("%s_show_busy%0d", nm, k), 32'(busy), 32'd1);
      chk($sformatf("%s_show_idx%0d", nm, k), 32'(digit_index), 32'd0);
      chk($sformatf("%s_hex%0d", nm, k), {4'd0, hex3, hex2, hex1, hex0},
          {4'd0, v.hex[0], v.hex[1], v.hex[2], v.hex[3]});
    end
    @(negedge clock);
    chk_idle({nm, "_end"});
  endtask

  // Reference model state: transfer active, edges since transfer, latched move.
  bit m_active;
  int m_k;
  int m_c[4];

  function automatic int m_slot_idx(input int s);
    return (s % 2 == 0) ? 9 + m_c[s] : 1 + m_c[s];
  endfunction

  initial begin
    vec_t v;
    int   cnt;
    logic [6:0] m_hex[4];

    vecs[0].fc = 3'd2; vecs[0].fr = 3'd5; vecs[0].tc = 3'd3; vecs[0].tr = 3'd4;
    vecs[0].idx = {5'd5, 5'd12, 5'd6, 5'd11};
    vecs[0].hex = {7'b0010010, 7'b0100001, 7'b0000010, 7'b1000110};
    vecs[1].fc = 3'd7; vecs[1].fr = 3'd7; vecs[1].tc = 3'd0; vecs[1].tr = 3'd0;
    vecs[1].idx = {5'd1, 5'd9, 5'd8, 5'd16};
    vecs[1].hex = {7'b1111001, 7'b0001000, 7'b0000000, 7'b0001001};
    vecs[2].fc = 3'd0; vecs[2].fr = 3'd0; vecs[2].tc = 3'd7; vecs[2].tr = 3'd7;
    vecs[2].idx = {5'd8, 5'd16, 5'd1, 5'd9};
    vecs[2].hex = {7'b0000000, 7'b0001001, 7'b1111001, 7'b0001000};
    vecs[3].fc = 3'd4; vecs[3].fr = 3'd2; vecs[3].tc = 3'd6; vecs[3].tr = 3'd3;
    vecs[3].idx = {5'd4, 5'd15, 5'd3, 5'd13};
    vecs[3].hex = {7'b0011001, 7'b1000010, 7'b0110000, 7'b0000110};

    resetn = 1'b0; move_valid = 1'b0; clear = 1'b0;
    from_col = 3'd0; from_row = 3'd0; to_col = 3'd0; to_row = 3'd0;
    repeat (2) @(negedge clock);
    chk_idle("reset");
    resetn = 1'b1;

    for (int i = 0; i < 4; i++) run_move(vecs[i], $sformatf("vec%0d", i));

    // Move offered continuously: second move waits until the first finishes.
    @(negedge clock);
    from_col = vecs[0].fc; from_row = vecs[0].fr; to_col = vecs[0].tc; to_row = vecs[0].tr;
    move_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    from_col = vecs[1].fc; from_row = vecs[1].fr; to_col = vecs[1].tc; to_row = vecs[1].tr;
    cnt = 0;
    while (busy === 1'b1 && cnt < 20) begin
      cnt++;
      @(negedge clock);
    end
    chk("held_busy_cycles", 32'(cnt), 32'(4 + HOLD));
    chk("held_ready", 32'(move_ready), 32'd1);
    @(posedge clock);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      if (k == 0) move_valid = 1'b0;
      chk($sformatf("held_idx%0d", k), 32'(digit_index), 32'(vecs[1].idx[k]));
    end
    repeat (HOLD + 1) @(negedge clock);
    chk_idle("held_end");

    // Clear on the edge that would capture slot 2.
    @(negedge clock);
    from_col = vecs[0].fc; from_row = vecs[0].fr; to_col = vecs[0].tc; to_row = vecs[0].tr;
    move_valid = 1'b1;
    @(posedge clock);
    @(negedge clock); move_valid = 1'b0;
    @(negedge clock);
    chk("clr_hex3_pre", 32'(hex3), 32'(vecs[0].hex[0]));
    @(negedge clock); clear = 1'b1;
    @(negedge clock); clear = 1'b0;
    chk_idle("clr_slot2");
    @(negedge clock);
    chk_idle("clr_slot2_after");

    // Clear and move_valid together in IDLE: no transfer.
    clear = 1'b1; move_valid = 1'b1;
    @(negedge clock);
    clear = 1'b0; move_valid = 1'b0;
    chk_idle("clr_vs_valid");
    @(negedge clock);
    chk_idle("clr_vs_valid_after");

    // Asynchronous reset during SHOW.
    @(negedge clock);
    move_valid = 1'b1;
    @(posedge clock);
    @(negedge clock); move_valid = 1'b0;
    repeat (5) @(negedge clock);
    chk("rst_pre_busy", 32'(busy), 32'd1);
    #1 resetn = 1'b0;
    #1 chk_idle("async_rst");
    @(posedge clock);
    #2 resetn = 1'b1;
    run_move(vecs[3], "post_rst");

    // Randomized traffic against the reference model.
    m_active = 1'b0; m_k = 0;
    for (int n = 0; n < 1500; n++) begin
      @(negedge clock);
      for (int s = 0; s < 4; s++)
        m_hex[s] = (m_active && m_k > s) ? seg_of(5'(m_slot_idx(s))) : 7'h7F;
      chk($sformatf("rnd%0d_idx", n), 32'(digit_index),
          (m_active && m_k < 4) ? 32'(m_slot_idx(m_k)) : 32'd0);
      chk($sformatf("rnd%0d_busy", n), 32'(busy), 32'(m_active));
      chk($sformatf("rnd%0d_ready", n), 32'(move_ready), 32'(!m_active));
      chk($sformatf("rnd%0d_hex", n), {4'd0, hex3, hex2, hex1, hex0},
          {4'd0, m_hex[0], m_hex[1], m_hex[2], m_hex[3]});
      clear      = ($urandom_range(0, 39) == 0);
      move_valid = ($urandom_range(0, 2) != 0);
      from_col = 3'($urandom); from_row = 3'($urandom);
      to_col   = 3'($urandom); to_row   = 3'($urandom);
      @(posedge clock);
      if (clear) begin
        m_active = 1'b0;
      end else if (!m_active) begin
        if (move_valid) begin
          m_active = 1'b1; m_k = 0;
          m_c[0] = int'(from_col); m_c[1] = int'(from_row);
          m_c[2] = int'(to_col);   m_c[3] = int'(to_row);
        end
      end else begin
        m_k++;
        if (m_k == 4 + HOLD) m_active = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
